// File: rtl/host_csr_pkg.sv
// Shared definitions for the host CSR responder: opcodes, register map,
// FSM encoding and the address decoder used by the responder.
package host_csr_pkg;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  localparam int unsigned CTRL_OFF = 32'h0000_0000;
  localparam int unsigned ECNT_OFF = 32'h0000_0004;
  localparam int unsigned VAL_BASE = 32'h0000_0008;

  localparam int unsigned CTRL_IDX = CTRL_OFF >> 2;
  localparam int unsigned ECNT_IDX = ECNT_OFF >> 2;
  localparam int unsigned VAL_IDX  = VAL_BASE >> 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] idx;
  } reg_sel_t;

  // Maps a byte address to a word index; misaligned or out-of-bank addresses are flagged invalid.
  function automatic reg_sel_t decode_addr(input logic [31:0] addr, input int unsigned num_regs);
    reg_sel_t sel;
    sel.valid = (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < num_regs);
    sel.idx   = addr[9:2];
    return sel;
  endfunction

endpackage

// File: rtl/host_csr_responder_if.sv
// Host request/response channel between the host bridge (master) and the
// device-side CSR responder (slave).
interface host_csr_responder_if #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 32
);
  logic                 req_valid;
  logic                 req_opcode;
  logic [ADDR_BITS-1:0] req_addr;
  logic [DATA_BITS-1:0] req_value;
  logic                 req_deq;
  logic                 resp_valid;
  logic [DATA_BITS-1:0] resp_bits;

  modport master (
    output req_valid, req_opcode, req_addr, req_value,
    input  req_deq, resp_valid, resp_bits
  );

  modport slave (
    input  req_valid, req_opcode, req_addr, req_value,
    output req_deq, resp_valid, resp_bits
  );
endinterface

// File: rtl/host_csr_responder.sv
// Device end of the host register-access protocol: accepts one request every
// two cycles, updates the CSR bank on writes and returns read data one cycle later.
module host_csr_responder
  import host_csr_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 32,
  parameter int NUM_VALS  = 2,
  parameter int NUM_PTRS  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  host_csr_responder_if.slave           host,
  output logic                          launch,
  input  logic                          finish,
  input  logic                          ecnt_valid,
  input  logic [DATA_BITS-1:0]          ecnt_value,
  output logic [NUM_VALS*DATA_BITS-1:0] vals,
  output logic [NUM_PTRS*DATA_BITS-1:0] ptrs
);

  localparam int unsigned NUM_REGS = VAL_IDX + NUM_VALS + NUM_PTRS;
  localparam int          IDX_W    = $clog2(NUM_REGS);
  localparam int unsigned PTR_IDX  = VAL_IDX + NUM_VALS;

  localparam logic [IDX_W-1:0]     CTRL_I    = IDX_W'(CTRL_IDX);
  localparam logic [IDX_W-1:0]     ECNT_I    = IDX_W'(ECNT_IDX);
  localparam logic [DATA_BITS-1:0] CTRL_DONE = DATA_BITS'(2'b10);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] value_q, value_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [DATA_BITS-1:0] resp_bits_q, resp_bits_d;
  logic [DATA_BITS-1:0] csr_q [NUM_REGS];
  logic [DATA_BITS-1:0] csr_d [NUM_REGS];

  reg_sel_t         wr_sel, rd_sel;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             accept;

  assign accept = (state_q == IDLE) && host.req_valid && !reset;

  // CSR next-state: host write first, then core-side finish/ecnt override their registers.
  always_comb begin
    csr_d  = csr_q;
    wr_sel = decode_addr(32'(addr_q), NUM_REGS);
    wr_idx = IDX_W'(wr_sel.idx);
    if ((state_q == WRITE) && wr_sel.valid) begin
      if (wr_idx == CTRL_I) begin
        csr_d[wr_idx] = {{(DATA_BITS-2){1'b0}}, value_q[1:0]};
      end else begin
        csr_d[wr_idx] = value_q;
      end
    end else begin
      csr_d = csr_q;
    end
    csr_d[CTRL_I] = finish     ? CTRL_DONE  : csr_d[CTRL_I];
    csr_d[ECNT_I] = ecnt_valid ? ecnt_value : csr_d[ECNT_I];
  end

  // Request FSM: accept in IDLE, commit in WRITE, present response during READ.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    value_d      = value_q;
    resp_valid_d = 1'b0;
    resp_bits_d  = '0;
    rd_sel       = decode_addr(32'(host.req_addr), NUM_REGS);
    rd_idx       = IDX_W'(rd_sel.idx);
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = host.req_addr;
          value_d = host.req_value;
          case (host.req_opcode)
            OP_WR: state_d = WRITE;
            OP_RD: begin
              state_d      = READ;
              resp_valid_d = 1'b1;
              // Read data sampled from next-state so same-edge updates are visible.
              resp_bits_d  = rd_sel.valid ? csr_d[rd_idx] : '0;
            end
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      WRITE:   state_d = IDLE;
      READ:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request, response and CSR bank registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      value_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_bits_q  <= '0;
      csr_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      value_q      <= value_d;
      resp_valid_q <= resp_valid_d;
      resp_bits_q  <= resp_bits_d;
      csr_q        <= csr_d;
    end
  end

  assign host.req_deq    = accept;
  assign host.resp_valid = resp_valid_q && !reset;
  assign host.resp_bits  = reset ? '0 : resp_bits_q;
  assign launch          = csr_q[CTRL_I][0];

  for (genvar g = 0; g < NUM_VALS; g++) begin : g_vals
    assign vals[g*DATA_BITS +: DATA_BITS] = csr_q[IDX_W'(VAL_IDX + g)];
  end

  for (genvar g = 0; g < NUM_PTRS; g++) begin : g_ptrs
    assign ptrs[g*DATA_BITS +: DATA_BITS] = csr_q[IDX_W'(PTR_IDX + g)];
  end

endmodule
